// File: rtl/sram_arbiter_pkg.sv
// Shared types and widths for the SRAM arbiter slice.
package sram_arbiter_pkg;
  localparam int WORD_AW = 17;
  localparam int RAM_AW  = 18;
  localparam int HALF_W  = 16;
  localparam int WORD_W  = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LO_SETUP = 3'd1,
    ST_LO_WAIT  = 3'd2,
    ST_HI_SETUP = 3'd3,
    ST_HI_WAIT  = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;
endpackage

// File: rtl/sram_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the side not granted last.
module rr_arbiter2
  import sram_arbiter_pkg::*;
(
  input  logic       req_if,
  input  logic       req_mem,
  input  owner_t     last_grant,
  output logic [1:0] grant        // [0] fetch, [1] memory stage
);
  // one-hot grant, empty when nobody asks
  always_comb begin
    grant = 2'b00;
    if (req_if && req_mem) grant = (last_grant == OWN_IF) ? 2'b10 : 2'b01;
    else                   grant = {req_mem, req_if};
  end
endmodule

// File: rtl/sram_arbiter.sv
// Shares one 16-bit async SRAM between fetch (read) and memory stage (read/write);
// each 32-bit word becomes two halfword cycles, low half first.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int RAM_WAIT = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 if_req,
  input  logic [WORD_AW-1:0]   if_addr,
  output logic                 if_ack,
  output logic [WORD_W-1:0]    if_rdata,
  input  logic                 mem_req,
  input  logic                 mem_we,
  input  logic [WORD_AW-1:0]   mem_addr,
  input  logic [WORD_W-1:0]    mem_wdata,
  output logic                 mem_ack,
  output logic [WORD_W-1:0]    mem_rdata,
  output logic [RAM_AW-1:0]    ram_addr,
  output logic [HALF_W-1:0]    ram_dout,
  input  logic [HALF_W-1:0]    ram_din,
  output logic                 ram_doe,
  output logic                 ram_wre,
  output logic                 ram_oute
);
  localparam logic [2:0] WAIT_LOAD = 3'(RAM_WAIT - 1);

  state_t              state;
  owner_t              owner, last_grant;
  logic                we;
  logic [WORD_AW-1:0]  addr;
  logic [WORD_W-1:0]   wdata;
  logic [HALF_W-1:0]   rd_lo;
  logic [2:0]          cnt;
  logic [1:0]          grant;

  rr_arbiter2 u_arb (
    .req_if     (if_req),
    .req_mem    (mem_req),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // winner's request fields, only meaningful while grant is non-zero
  logic               win_mem, win_we;
  logic [WORD_AW-1:0] win_addr;
  assign win_mem  = grant[1];
  assign win_we   = grant[1] & mem_we;
  assign win_addr = grant[1] ? mem_addr : if_addr;

  // FSM; SRAM controls and acks are registered for the state being entered
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      owner      <= OWN_IF;
      last_grant <= OWN_IF;
      we         <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      rd_lo      <= '0;
      cnt        <= '0;
      if_ack     <= 1'b0;
      mem_ack    <= 1'b0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
      ram_addr   <= '0;
      ram_dout   <= '0;
      ram_doe    <= 1'b0;
      ram_wre    <= 1'b1;
      ram_oute   <= 1'b1;
    end else begin
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;
      case (state)
        ST_IDLE: if (|grant) begin
          owner      <= win_mem ? OWN_MEM : OWN_IF;
          last_grant <= win_mem ? OWN_MEM : OWN_IF;
          we         <= win_we;
          addr       <= win_addr;
          wdata      <= mem_wdata;
          ram_addr   <= {win_addr, 1'b0};
          if (win_we) begin
            ram_doe  <= 1'b1;
            ram_dout <= mem_wdata[15:0];
          end else begin
            ram_oute <= 1'b0;
          end
          state <= ST_LO_SETUP;
        end
        ST_LO_SETUP, ST_HI_SETUP: begin
          cnt <= WAIT_LOAD;
          if (we) ram_wre <= 1'b0;
          state <= (state == ST_LO_SETUP) ? ST_LO_WAIT : ST_HI_WAIT;
        end
        ST_LO_WAIT: begin
          if (cnt == 3'd0) begin
            if (!we) rd_lo <= ram_din;
            ram_addr <= {addr, 1'b1};
            if (we) begin
              ram_wre  <= 1'b1;
              ram_dout <= wdata[31:16];
            end
            state <= ST_HI_SETUP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        ST_HI_WAIT: begin
          if (cnt == 3'd0) begin
            ram_wre  <= 1'b1;
            ram_oute <= 1'b1;
            ram_doe  <= 1'b0;
            if (!we) begin
              if (owner == OWN_IF) if_rdata  <= {ram_din, rd_lo};
              else                 mem_rdata <= {ram_din, rd_lo};
            end
            if (owner == OWN_IF) if_ack  <= 1'b1;
            else                 mem_ack <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized scoreboard bench: word-level reference memory plus arbitration rule,
// halfword SRAM model on the pins, monitor compares every ack.
module tb_sram_arbiter;
  localparam int W    = 1;
  localparam int LAT  = 2 * (W + 1) + 1;
  localparam int STEP = 2 * (W + 1) + 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [16:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [16:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [17:0] ram_addr;
  logic [15:0] ram_dout;
  logic [15:0] ram_din;
  logic        ram_doe, ram_wre, ram_oute;

  sram_arbiter #(.RAM_WAIT(W)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_din(ram_din),
    .ram_doe(ram_doe), .ram_wre(ram_wre), .ram_oute(ram_oute)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // pin-level SRAM: writes while write-enable is low at a clock edge, reads combinationally
  bit [15:0] sram [0:262143];
  assign ram_din = !ram_oute ? sram[ram_addr] : 16'h0000;
  always @(posedge clock) if (!ram_wre) sram[ram_addr] = ram_dout;

  // word-level reference
  bit [31:0] ref_mem [0:131071];
  bit        ref_last_mem = 1'b0;

  typedef struct {
    bit        own_mem;
    bit        we;
    bit [16:0] addr;
    bit [31:0] data;
    int        exp_cyc;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int failures = 0;
  bit [31:0] exp_if_rd = '0, exp_mem_rd = '0;
  int oute_n = 0, wre_n = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic on_ack(bit m);
    exp_t e;
    if (sbq.size() == 0) begin
      chk(m ? "unexpected_mem_ack" : "unexpected_if_ack", 1, 0);
      return;
    end
    e = sbq.pop_front();
    chk("ack_owner", m, e.own_mem);
    chk("ack_cycle", cyc, e.exp_cyc);
    if (!e.we) begin
      if (e.own_mem) exp_mem_rd = e.data;
      else           exp_if_rd  = e.data;
      chk("read_oute_low_cycles", oute_n, 2 * (W + 1));
      chk("read_wre_low_cycles", wre_n, 0);
    end else begin
      chk("write_wre_low_cycles", wre_n, 2 * W);
      chk("write_oute_low_cycles", oute_n, 0);
      chk("sram_lo_half", sram[{e.addr, 1'b0}], e.data[15:0]);
      chk("sram_hi_half", sram[{e.addr, 1'b1}], e.data[31:16]);
    end
    chk("if_rdata", if_rdata, exp_if_rd);
    chk("mem_rdata", mem_rdata, exp_mem_rd);
    oute_n = 0;
    wre_n  = 0;
  endtask

  // monitor: pin invariants every cycle, scoreboard pop on every ack
  always @(negedge clock) begin
    if (!reset) begin
      oute_n = 0;
      wre_n  = 0;
    end else begin
      if (!ram_oute) oute_n++;
      if (!ram_wre)  wre_n++;
      if (!ram_wre && !ram_oute) chk("wre_oute_both_low", 1, 0);
      if (ram_doe && !ram_oute)  chk("doe_during_read", 1, 0);
      if (if_ack)  on_ack(1'b0);
      if (mem_ack) on_ack(1'b1);
    end
  end

  task automatic check_reset_outputs(string tag);
    chk({tag, "_if_ack"}, if_ack, 0);
    chk({tag, "_mem_ack"}, mem_ack, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_mem_rdata"}, mem_rdata, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_ram_dout"}, ram_dout, 0);
    chk({tag, "_ram_doe"}, ram_doe, 0);
    chk({tag, "_ram_wre"}, ram_wre, 1);
    chk({tag, "_ram_oute"}, ram_oute, 1);
  endtask

  // one round: both requests raised together in IDLE, held until their acks
  task automatic issue(bit do_if, bit [16:0] ia, bit do_mem, bit mwe,
                       bit [16:0] ma, bit [31:0] md, bit scramble);
    exp_t e;
    bit first_mem;
    int t0, n, k;
    @(posedge clock); #1;
    t0 = cyc;
    first_mem = do_mem && (!do_if || !ref_last_mem);
    k = 0;
    for (int i = 0; i < 2; i++) begin
      bit m = (i == 0) ? first_mem : !first_mem;
      if ((m && do_mem) || (!m && do_if)) begin
        e.own_mem = m;
        e.we      = m && mwe;
        e.addr    = m ? ma : ia;
        e.exp_cyc = t0 + LAT + k * STEP;
        if (e.we) begin
          e.data = md;
          ref_mem[e.addr] = md;
        end else begin
          e.data = ref_mem[e.addr];
        end
        ref_last_mem = m;
        sbq.push_back(e);
        k++;
      end
    end
    if_addr = ia; if_req = do_if;
    mem_addr = ma; mem_we = mwe; mem_wdata = md; mem_req = do_mem;
    n = 0;
    while ((if_req || mem_req) && n < 200) begin
      @(negedge clock);
      n++;
      if (if_ack)  if_req  = 1'b0;
      if (mem_ack) mem_req = 1'b0;
      if (scramble && n == 2) begin
        if_addr = 17'($urandom); mem_addr = 17'($urandom);
        mem_wdata = $urandom; mem_we = 1'($urandom);
      end
    end
    if (if_req || mem_req) begin
      chk("ack_timeout", 1, 0);
      if_req = 1'b0; mem_req = 1'b0;
    end
  endtask

  function automatic bit [16:0] pick_addr();
    case ($urandom_range(0, 3))
      0: return 17'h00010;
      1: return 17'h1FFFF;
      2: return 17'h00000;
      default: return 17'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    int t0;
    bit [31:0] old;
    sram[{17'h00010, 1'b0}] = 16'h5678;
    sram[{17'h00010, 1'b1}] = 16'h1234;
    ref_mem[17'h00010] = 32'h12345678;

    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b1;

    // directed: fetch read, memory write at the top word, read back, tie
    issue(1, 17'h00010, 0, 0, 17'h0, 32'h0, 0);
    issue(0, 17'h0, 1, 1, 17'h1FFFF, 32'hDEADBEEF, 1);
    issue(0, 17'h0, 1, 0, 17'h1FFFF, 32'h0, 0);
    issue(1, 17'h1FFFF, 1, 1, 17'h00010, 32'hCAFEF00D, 0);
    issue(1, 17'h00010, 1, 0, 17'h00010, 32'h0, 0);

    // randomized rounds
    for (int r = 0; r < 40; r++) begin
      bit di = 1'($urandom), dm = 1'($urandom);
      if (!di && !dm) di = 1'b1;
      issue(di, pick_addr(), dm, 1'($urandom), pick_addr(), $urandom,
            !(di && dm) && 1'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clock);
    end

    // reset in the first HI_WAIT cycle of a write
    @(posedge clock); #1;
    t0 = cyc;
    old = ref_mem[17'h00020];
    mem_addr = 17'h00020; mem_we = 1'b1; mem_wdata = 32'hA5A55A5A; mem_req = 1'b1;
    while (cyc < t0 + 3 + W) @(negedge clock);
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    mem_req = 1'b0;
    ref_mem[17'h00020] = {old[31:16], 16'h5A5A};
    ref_last_mem = 1'b0;
    exp_if_rd = '0; exp_mem_rd = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    issue(1, 17'h00020, 1, 0, 17'h00020, 32'h0, 0);

    repeat (4) @(posedge clock);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
